inertial_delay_filter: RTL
==========================

Name: inertial_delay_filter

Overview:
- Synthesizable, clocked, multi-channel successor to net/assignment delay modelling; delays are counted in clock cycles, not simulation time.
- Per channel, runtime-selectable mode:
  - Inertial: an input change reaches the output only if it holds stable for DELAY cycles; shorter pulses are rejected.
  - Transport: every input value reaches the output exactly DELAY cycles later.
- Sits between raw, glitchy or asynchronous-derived status buses and downstream control logic.

Parameters:
- WIDTH, 2, bits per channel.
- CHANNELS, 4, number of independent channels.
- DELAY, 10, delay in clock cycles; legal range 1..1023; elaboration error outside this range.
- RST_VAL, 0, WIDTH-bit reset value of every channel output and of all internal state.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, clock enable; when 0, all state freezes.
- mode, input, CHANNELS, per-channel mode; 0 = inertial, 1 = transport.
- din, input, CHANNELS*WIDTH, channel c occupies bits [c*WIDTH +: WIDTH].
- dout, output, CHANNELS*WIDTH, filtered or delayed value, registered.
- change_stb, output, CHANNELS, one-cycle pulse in the cycle dout[c] changes value.
- rejected, output, CHANNELS, one-cycle pulse when a pending inertial candidate is abandoned.

Behaviour:
- Reset (rst_n low, asynchronous): every dout channel = RST_VAL; change_stb = 0; rejected = 0; pend_valid = 0; counters = 0; transport delay-line stages = RST_VAL.
- All outputs are registered; no combinational path from din to any output.
- en = 0: din is not sampled; all state holds; change_stb = 0; rejected = 0.
- Inertial mode, per channel, per enabled edge:
  - din == dout with pend_valid = 1: clear pend_valid; rejected pulses.
  - din == dout with pend_valid = 0: no action.
  - din != dout and (pend_valid = 0 or din != pend_val): pend_val <= din; cnt <= 1; pend_valid <= 1. If a different candidate was pending, rejected pulses.
  - din == pend_val: cnt increments. On the edge where cnt would reach DELAY: dout <= pend_val; pend_valid <= 0; change_stb pulses.
  - DELAY = 1: a new candidate commits on its first sample.
  - Latency: din changes before edge N and holds; dout changes after edge N+DELAY-1, i.e. DELAY cycles.
- Transport mode, per channel:
  - Shift register of DELAY stages; dout = din sampled DELAY enabled cycles earlier.
  - Pulses of any length, including 1 cycle, propagate unchanged.
  - change_stb pulses whenever dout changes; rejected is always 0.
- Mode change on a channel (mode[c] differs from its registered copy):
  - Flush that channel: pend_valid <= 0; cnt <= 0; all delay stages <= current dout.
  - dout holds; no change_stb; no rejected.
  - The new mode takes effect from the next enabled edge.
- Reset mid-operation: in-flight candidates and delay-line contents are discarded; no strobe at or after release until a fresh qualifying change.
- Counter width: clog2(DELAY+1) bits; the counter never wraps because it is cleared on commit.
- Channels are fully independent; simultaneous events on different channels are legal.

Optional Feature:
- Macro: INERTIAL_DELAY_STATS_EN.
- With the macro defined:
  - Adds output port reject_cnt, CHANNELS*16 bits.
  - Per channel, a saturating count of rejected pulses: stops at 16'hFFFF; reset to 0; frozen when en = 0; not cleared by mode flush.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package inertial_delay_pkg holds:
  - MODE_INERTIAL = 1'b0, MODE_TRANSPORT = 1'b1;
  - STAT_W = 16;
  - MAX_DELAY = 1023.
- Sub-module inertial_delay_channel, parameterised by WIDTH, DELAY and RST_VAL:
  - holds one channel's pending/counter logic, delay line and stats counter;
  - the top instantiates it CHANNELS times with a generate loop and does the bus slicing.

Test Plan (WIDTH=2, CHANNELS=4, DELAY=10, RST_VAL=0):
- Inertial: ch0 din 00→10 at cycle 0, held -> dout[1:0]=10 exactly 10 cycles later; change_stb[0] high for 1 cycle; rejected=0.
- Inertial glitch: ch1 din 00→11 for 2 cycles, then back to 00 -> dout unchanged at 00; rejected[1] pulses on the return cycle; reject_cnt ch1 = 1 when stats are enabled.
- Transport: ch2 mode=1; din 00→11 for 2 cycles, then 00 -> dout shows 11 for exactly 2 cycles, starting 10 cycles later; two change_stb pulses.
- en low for 3 cycles during an inertial count: 10 held on ch3 -> commit after 13 cycles instead of 10.
- Reset at cycle 5 of a pending change -> dout = 00 immediately; held din 10 commits 10 cycles after rst_n releases.
- Mode switch inertial→transport with pending 01 at cnt=4 -> no strobe; the delay line reads 00 for 10 cycles, then follows din.

Source files
------------

// File: rtl/inertial_delay_pkg.sv
// rtl/inertial_delay_pkg.sv - shared constants and types for the inertial delay filter
//
// Purpose: mode encoding, stats counter width, delay limit and a saturating
// increment helper used by inertial_delay_channel and inertial_delay_filter.

package inertial_delay_pkg;

    typedef enum logic {
        MODE_INERTIAL  = 1'b0,
        MODE_TRANSPORT = 1'b1
    } mode_e;

    localparam int STAT_W    = 16;
    localparam int MAX_DELAY = 1023;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
        return (val == {STAT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/inertial_delay_channel.sv
// rtl/inertial_delay_channel.sv - one channel of the inertial/transport delay filter
//
// Purpose: per-channel pending candidate + counter (inertial mode), delay
// line (transport mode), mode-change flush and optional rejection counter.
// Optional feature macro: INERTIAL_DELAY_STATS_EN (adds reject_cnt).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            clock enable; all state freezes when low
//   mode          0 = inertial, 1 = transport
//   din           raw channel value
//   dout          filtered / delayed value (registered)
//   change_stb    one-cycle pulse in the cycle dout changes
//   rejected      one-cycle pulse when a pending candidate is abandoned
//   reject_cnt    saturating count of rejected pulses (stats build only)

module inertial_delay_channel
    import inertial_delay_pkg::*;
#(
    parameter int               WIDTH   = 2,
    parameter int               DELAY   = 10,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              change_stb,
    output logic              rejected
`ifdef INERTIAL_DELAY_STATS_EN
    ,
    output logic [STAT_W-1:0] reject_cnt
`endif
);

    localparam int CW = $clog2(DELAY + 1);
    // dout is the last transport stage, so only DELAY-1 stages live in the line.
    localparam int LINE_N = (DELAY > 1) ? DELAY - 1 : 1;
    localparam int TAP    = LINE_N - 1;

    mode_e            mode_q,       mode_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_val_q,   pend_val_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             stb_q,        stb_d;
    logic             rej_q,        rej_d;
    logic [WIDTH-1:0] line_q [LINE_N];
    logic [WIDTH-1:0] line_d [LINE_N];
    logic [WIDTH-1:0] tap;

    always_comb begin
        mode_d       = mode_q;
        pend_valid_d = pend_valid_q;
        pend_val_d   = pend_val_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        stb_d        = 1'b0;
        rej_d        = 1'b0;
        line_d       = line_q;
        tap          = (DELAY == 1) ? din : line_q[TAP];

        if (en) begin
            if (mode != mode_q) begin
                // Flush: forget history, line refilled with the held output.
                mode_d       = mode_e'(mode);
                pend_valid_d = 1'b0;
                cnt_d        = '0;
                for (int i = 0; i < LINE_N; i++) begin
                    line_d[i] = dout_q;
                end
            end else if (mode_q == MODE_TRANSPORT) begin
                line_d[0] = din;
                for (int i = 1; i < LINE_N; i++) begin
                    line_d[i] = line_q[i-1];
                end
                dout_d = tap;
                stb_d  = (tap != dout_q);
            end else begin
                if (din == dout_q) begin
                    if (pend_valid_q) begin
                        pend_valid_d = 1'b0;
                        cnt_d        = '0;
                        rej_d        = 1'b1;
                    end
                end else if (!pend_valid_q || din != pend_val_q) begin
                    rej_d = pend_valid_q;
                    if (DELAY == 1) begin
                        dout_d       = din;
                        stb_d        = 1'b1;
                        pend_valid_d = 1'b0;
                        cnt_d        = '0;
                    end else begin
                        pend_val_d   = din;
                        pend_valid_d = 1'b1;
                        cnt_d        = CW'(1);
                    end
                end else if (cnt_q == CW'(DELAY - 1)) begin
                    dout_d       = pend_val_q;
                    stb_d        = 1'b1;
                    pend_valid_d = 1'b0;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_INERTIAL;
            pend_valid_q <= 1'b0;
            pend_val_q   <= RST_VAL;
            cnt_q        <= '0;
            dout_q       <= RST_VAL;
            stb_q        <= 1'b0;
            rej_q        <= 1'b0;
            for (int i = 0; i < LINE_N; i++) begin
                line_q[i] <= RST_VAL;
            end
        end else begin
            mode_q       <= mode_d;
            pend_valid_q <= pend_valid_d;
            pend_val_q   <= pend_val_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            stb_q        <= stb_d;
            rej_q        <= rej_d;
            line_q       <= line_d;
        end
    end

    assign dout       = dout_q;
    assign change_stb = stb_q;
    assign rejected   = rej_q;

`ifdef INERTIAL_DELAY_STATS_EN
    logic [STAT_W-1:0] stat_q;

    // rej_d is already gated by en, so the count freezes with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (rej_d) begin
            stat_q <= sat_inc(stat_q);
        end
    end

    assign reject_cnt = stat_q;
`endif

endmodule

// File: rtl/inertial_delay_filter.sv
// rtl/inertial_delay_filter.sv - multi-channel clocked inertial/transport delay filter
//
// Purpose: CHANNELS independent delay filters; each channel selects
// inertial (glitch rejection) or transport (pure delay) at runtime.
// Optional feature macro: INERTIAL_DELAY_STATS_EN (adds reject_cnt).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            clock enable for all channels
//   mode          per-channel mode, 0 = inertial, 1 = transport
//   din           channel c at [c*WIDTH +: WIDTH]
//   dout          filtered / delayed values (registered)
//   change_stb    per-channel one-cycle pulse when dout changes
//   rejected      per-channel one-cycle pulse when a candidate is abandoned
//   reject_cnt    per-channel 16-bit saturating reject count (stats build only)

module inertial_delay_filter
    import inertial_delay_pkg::*;
#(
    parameter int               WIDTH    = 2,
    parameter int               CHANNELS = 4,
    parameter int               DELAY    = 10,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [CHANNELS-1:0]          mode,
    input  logic [CHANNELS*WIDTH-1:0]    din,
    output logic [CHANNELS*WIDTH-1:0]    dout,
    output logic [CHANNELS-1:0]          change_stb,
    output logic [CHANNELS-1:0]          rejected
`ifdef INERTIAL_DELAY_STATS_EN
    ,
    output logic [CHANNELS*STAT_W-1:0]   reject_cnt
`endif
);

    if (DELAY < 1 || DELAY > MAX_DELAY) begin : g_bad_delay
        $error("inertial_delay_filter: DELAY must be in 1..1023");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        inertial_delay_channel #(
            .WIDTH   (WIDTH),
            .DELAY   (DELAY),
            .RST_VAL (RST_VAL)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .mode       (mode[c]),
            .din        (din[c*WIDTH +: WIDTH]),
            .dout       (dout[c*WIDTH +: WIDTH]),
            .change_stb (change_stb[c]),
            .rejected   (rejected[c])
`ifdef INERTIAL_DELAY_STATS_EN
            ,
            .reject_cnt (reject_cnt[c*STAT_W +: STAT_W])
`endif
        );
    end

endmodule
